fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues one-cycle-latency reads at pc, buffers the returned word when the
// decode slot is still occupied, and presents instructions on IR/ir_pc with a
// valid/ready handshake. A redirect flushes everything and restarts at
// redirect_pc. One instruction per two cycles when memory and decode never stall.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] mem_data,
  input  logic        mem_busy,
  output logic        MemRead,
  output logic [15:0] ADDR,
  input  logic        ir_ready,
  output logic [15:0] IR,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  // REQ: may issue a read; WAIT: read data is on mem_data this cycle;
  // HOLD: returned word parked in the buffer until the output slot frees up.
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state_q,    state_d;
  logic [15:0] pc_q,       pc_d;
  logic [15:0] buf_q,      buf_d;
  logic [15:0] buf_pc_q,   buf_pc_d;
  logic [15:0] ir_q,       ir_d;
  logic [15:0] ir_pc_q,    ir_pc_d;
  logic        ir_valid_q, ir_valid_d;

  logic        slot_free;

  // The output slot can take a new word if it is empty or being consumed now.
  assign slot_free = !ir_valid_q || ir_ready;

  // Read request is purely combinational so a redirect or reset in the same
  // cycle suppresses it; memory is never asked for a word we would discard.
  assign MemRead = (state_q == ST_REQ) && !mem_busy && !redirect && !reset;

  assign ADDR     = pc_q;
  assign IR       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;

  // Next-state logic: redirect wins over everything, then per-state behaviour.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    buf_pc_d   = buf_pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;

    if (redirect) begin
      // Flush: any word in flight or buffered is dropped, and the current IR
      // is invalidated whether or not decode took it this cycle.
      pc_d       = redirect_pc;
      ir_valid_d = 1'b0;
      buf_d      = 16'h0000;
      buf_pc_d   = 16'h0000;
      state_d    = ST_REQ;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (ir_valid_q && ir_ready) begin
            ir_valid_d = 1'b0;
          end
          if (MemRead) begin
            state_d = ST_WAIT;
          end
        end

        ST_WAIT: begin
          // Data for pc_q is on mem_data now; always capture it and advance pc.
          buf_d    = mem_data;
          buf_pc_d = pc_q;
          pc_d     = pc_q + 16'd1;
          if (slot_free) begin
            ir_d       = mem_data;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            state_d    = ST_REQ;
          end else begin
            state_d = ST_HOLD;
          end
        end

        ST_HOLD: begin
          // Buffer is frozen here; mem_data is ignored until we go back to REQ.
          if (slot_free) begin
            ir_d       = buf_q;
            ir_pc_d    = buf_pc_q;
            ir_valid_d = 1'b1;
            state_d    = ST_REQ;
          end
        end

        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
  end

  // State registers; reset clears everything immediately and restarts at RESET_PC.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      buf_q      <= 16'h0000;
      buf_pc_q   <= 16'h0000;
      ir_q       <= 16'h0000;
      ir_pc_q    <= 16'h0000;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      buf_pc_q   <= buf_pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized stall/redirect/reset
// traffic, checked every cycle against a transaction-level fetch model.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        reset;
  logic [15:0] mem_data;
  logic        mem_busy;
  logic        MemRead;
  logic [15:0] ADDR;
  logic        ir_ready;
  logic [15:0] IR;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        redirect;
  logic [15:0] redirect_pc;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .mem_data    (mem_data),
    .mem_busy    (mem_busy),
    .MemRead     (MemRead),
    .ADDR        (ADDR),
    .ir_ready    (ir_ready),
    .IR          (IR),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Contents of the instruction memory seen by the fetch unit.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] t;
    case (a)
      16'd0:   return 16'h27E7;
      16'd1:   return 16'h27E7;
      16'd2:   return 16'h246C;
      default: begin
        t = a * 16'd40503 + 16'd12345;
        return t ^ 16'h0F0F;
      end
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  // Tracks: the next fetch address, an outstanding read (address), words
  // fetched but not yet presented, and the presented instruction.
  logic [15:0] m_pc, m_ir, m_irpc, m_infl_a;
  bit          m_irv, m_infl;
  logic [15:0] pq_a[$];
  logic [15:0] pq_d[$];

  task automatic m_reset();
    m_pc = 16'h0000; m_ir = 16'h0000; m_irpc = 16'h0000;
    m_irv = 1'b0; m_infl = 1'b0; m_infl_a = 16'h0000;
    pq_a.delete(); pq_d.delete();
  endtask

  function automatic bit m_idle();
    return !m_infl && (pq_a.size() == 0);
  endfunction

  task automatic m_step();
    bit free;
    logic [15:0] w;
    free = !m_irv || ir_ready;
    if (redirect) begin
      m_pc = redirect_pc; m_irv = 1'b0; m_infl = 1'b0;
      pq_a.delete(); pq_d.delete();
    end else if (m_infl) begin
      w = mem_word(m_infl_a);
      m_pc = m_pc + 16'd1;
      m_infl = 1'b0;
      if (free) begin m_ir = w; m_irpc = m_infl_a; m_irv = 1'b1; end
      else begin pq_a.push_back(m_infl_a); pq_d.push_back(w); end
    end else if (pq_a.size() != 0) begin
      if (free) begin m_ir = pq_d.pop_front(); m_irpc = pq_a.pop_front(); m_irv = 1'b1; end
    end else begin
      if (m_irv && ir_ready) m_irv = 1'b0;
      if (!mem_busy) begin m_infl = 1'b1; m_infl_a = m_pc; end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge CLK or posedge reset);
      if (reset) m_reset();
      else m_step();
    end
  end

  // ---------------- memory responder: one-cycle latency, garbage otherwise ----------------
  initial begin
    logic        rv;
    logic [15:0] ra;
    mem_data = 16'h0000;
    forever begin
      @(negedge CLK);
      rv = MemRead;
      ra = ADDR;
      @(posedge CLK);
      #1;
      mem_data = rv ? mem_word(ra) : 16'($urandom);
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    logic exp_rd;
    forever begin
      @(negedge CLK);
      exp_rd = !reset && !redirect && !mem_busy && m_idle();
      chk("cmp_MemRead", {15'd0, MemRead}, {15'd0, exp_rd});
      chk("cmp_ADDR", ADDR, m_pc);
      chk("cmp_ir_valid", {15'd0, ir_valid}, {15'd0, m_irv});
      if (m_irv) begin
        chk("cmp_IR", IR, m_ir);
        chk("cmp_ir_pc", ir_pc, m_irpc);
      end
      if (!reset && ir_valid && ir_ready)
        $display("txn: IR=%h ir_pc=%h accepted", IR, ir_pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  // Holds reset for two edges, checks the reset state, releases reset so the
  // caller is in the first cycle after deassertion.
  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
    mem_busy = 1'b0; ir_ready = 1'b1;
    nxt(); nxt();
    neg();
    chk("rst_ir_valid", {15'd0, ir_valid}, 16'd0);
    chk("rst_MemRead", {15'd0, MemRead}, 16'd0);
    chk("rst_IR", IR, 16'h0000);
    chk("rst_ir_pc", ir_pc, 16'h0000);
    chk("rst_ADDR", ADDR, 16'h0000);
    nxt();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_busy = 1'b0; ir_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 16'h0000;

    // Basic stream: reads on cycles 1,3,5, IRs 27E7/27E7/246C.
    do_reset();
    neg(); chk("s1_c1_rd", {15'd0, MemRead}, 16'd1); chk("s1_c1_addr", ADDR, 16'h0000);
    nxt(); neg(); chk("s1_c2_rd", {15'd0, MemRead}, 16'd0);
    nxt(); neg(); chk("s1_c3_ir", IR, 16'h27E7); chk("s1_c3_pc", ir_pc, 16'h0000);
    chk("s1_c3_v", {15'd0, ir_valid}, 16'd1);
    chk("s1_c3_rd", {15'd0, MemRead}, 16'd1); chk("s1_c3_addr", ADDR, 16'h0001);
    nxt(); neg(); chk("s1_c4_v", {15'd0, ir_valid}, 16'd0);
    nxt(); neg(); chk("s1_c5_ir", IR, 16'h27E7); chk("s1_c5_pc", ir_pc, 16'h0001);
    chk("s1_c5_rd", {15'd0, MemRead}, 16'd1); chk("s1_c5_addr", ADDR, 16'h0002);
    nxt(); nxt(); neg(); chk("s1_c7_ir", IR, 16'h246C); chk("s1_c7_pc", ir_pc, 16'h0002);

    // Decode stall: second word parked in HOLD, no reads, then released.
    do_reset();
    nxt(); nxt();
    ir_ready = 1'b0;
    neg(); chk("s2_c3_ir", IR, 16'h27E7); chk("s2_c3_rd", {15'd0, MemRead}, 16'd1);
    for (int c = 4; c <= 8; c++) begin
      nxt(); neg();
      chk("s2_hold_rd", {15'd0, MemRead}, 16'd0);
      chk("s2_hold_ir", IR, 16'h27E7);
      chk("s2_hold_pc", ir_pc, 16'h0000);
    end
    nxt(); ir_ready = 1'b1;
    neg(); chk("s2_c9_rd", {15'd0, MemRead}, 16'd0);
    nxt(); neg();
    chk("s2_c10_ir", IR, 16'h27E7); chk("s2_c10_pc", ir_pc, 16'h0001);
    chk("s2_c10_rd", {15'd0, MemRead}, 16'd1); chk("s2_c10_addr", ADDR, 16'h0002);

    // Memory port busy at pc=4 for three cycles.
    nxt(); nxt(); nxt(); nxt();
    mem_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      neg();
      chk("s3_busy_rd", {15'd0, MemRead}, 16'd0);
      chk("s3_busy_addr", ADDR, 16'h0004);
      nxt();
    end
    mem_busy = 1'b0;
    neg(); chk("s3_rel_rd", {15'd0, MemRead}, 16'd1); chk("s3_rel_addr", ADDR, 16'h0004);
    nxt(); nxt(); neg();
    chk("s3_ir", IR, mem_word(16'h0004)); chk("s3_pc", ir_pc, 16'h0004);

    // Redirect to 5 while word 3 is returning.
    do_reset();
    for (int c = 0; c < 7; c++) nxt();
    redirect = 1'b1; redirect_pc = 16'h0005;
    neg(); chk("s4_wait_rd", {15'd0, MemRead}, 16'd0);
    nxt(); redirect = 1'b0;
    neg(); chk("s4_v", {15'd0, ir_valid}, 16'd0);
    chk("s4_rd", {15'd0, MemRead}, 16'd1); chk("s4_addr", ADDR, 16'h0005);
    nxt(); nxt(); neg();
    chk("s4_ir", IR, mem_word(16'h0005)); chk("s4_pc", ir_pc, 16'h0005);

    // Wrap: fetch from FFFF, next read at 0000.
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    nxt(); redirect = 1'b0;
    neg(); chk("s5_addr", ADDR, 16'hFFFF); chk("s5_rd", {15'd0, MemRead}, 16'd1);
    nxt(); nxt();
    ir_ready = 1'b0;
    neg(); chk("s5_ir", IR, mem_word(16'hFFFF)); chk("s5_pc", ir_pc, 16'hFFFF);
    chk("s5_next_addr", ADDR, 16'h0000); chk("s5_next_rd", {15'd0, MemRead}, 16'd1);

    // Asynchronous reset in HOLD.
    nxt(); nxt(); neg();
    chk("s6_hold_rd", {15'd0, MemRead}, 16'd0);
    chk("s6_hold_v", {15'd0, ir_valid}, 16'd1);
    #2 reset = 1'b1;
    #1;
    chk("s6_async_v", {15'd0, ir_valid}, 16'd0);
    chk("s6_async_rd", {15'd0, MemRead}, 16'd0);
    chk("s6_async_ir", IR, 16'h0000);
    chk("s6_async_addr", ADDR, 16'h0000);
    ir_ready = 1'b1;
    nxt(); nxt();
    reset = 1'b0;
    neg(); chk("s6_rel_rd", {15'd0, MemRead}, 16'd1); chk("s6_rel_addr", ADDR, 16'h0000);
    nxt();

    // Randomized traffic, checked by the per-cycle compare.
    for (int c = 0; c < 1500; c++) begin
      mem_busy = ($urandom_range(0, 99) < 25);
      ir_ready = ($urandom_range(0, 99) < 65);
      redirect = ($urandom_range(0, 99) < 4);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (16'hFFFE + 16'($urandom_range(0, 3)))
                                                : 16'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      nxt();
    end
    reset = 1'b0; redirect = 1'b0;
    nxt(); nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
